// File: rtl/bf_tape_ctrl_if.sv
// CPU op port and host debug port of the Brainfuck tape controller.
// The master side is the CPU core / host; the slave side is bf_tape_ctrl.
interface bf_tape_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
);

  logic              cmd_valid;
  logic [2:0]        cmd_op;
  logic [DATA_W-1:0] cmd_wdata;
  logic              cmd_ready;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              zero_flag;
  logic [ADDR_W-1:0] ptr;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic [DATA_W-1:0] dbg_rdata;

  modport master (
    output cmd_valid, cmd_op, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_data, zero_flag, ptr,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_gnt, dbg_rvalid, dbg_rdata
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_data, zero_flag, ptr,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_gnt, dbg_rvalid, dbg_rdata
  );

endinterface

// File: rtl/bf_tape_ctrl.sv
// Brainfuck data tape controller: owns the data pointer and shares the single
// tape RAM port between CPU ops, host debug accesses and a soft clear sweep.
module bf_tape_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              nrst,
  bf_tape_ctrl_if.slave     bus,
  input  logic              clr_start_i,
  output logic              clr_busy_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i
);

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_INC   = 3'd1,
    OP_DEC   = 3'd2,
    OP_RIGHT = 3'd3,
    OP_LEFT  = 3'd4,
    OP_LOAD  = 3'd5,
    OP_PEEK  = 3'd6,
    OP_NOP7  = 3'd7
  } op_t;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] DATA_ONE = {{(DATA_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] CNT_LAST = {ADDR_W{1'b1}};

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              last_dbg_q, last_dbg_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              dbg_rvalid_q, dbg_rvalid_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;

  op_t  op;
  logic dbg_wins;
  logic port_open;
  logic cmd_ready;
  logic dbg_gnt;
  logic cmd_accept;

  assign op = op_t'(bus.cmd_op);

  // Round-robin between host and CPU: on contention, whoever was not served
  // last time wins, so neither side can starve the other.
  assign dbg_wins   = bus.dbg_req & (~bus.cmd_valid | ~last_dbg_q);
  assign port_open  = nrst & (state_q == S_IDLE) & ~clr_start_i;
  assign cmd_ready  = port_open & ~dbg_wins;
  assign dbg_gnt    = port_open & dbg_wins;
  assign cmd_accept = cmd_ready & bus.cmd_valid;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      ptr_q        <= '0;
      last_dbg_q   <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      dbg_rvalid_q <= 1'b0;
      dbg_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ptr_q        <= ptr_d;
      last_dbg_q   <= last_dbg_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      dbg_rvalid_q <= dbg_rvalid_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ptr_d        = ptr_q;
    last_dbg_d   = last_dbg_q;
    rsp_valid_d  = 1'b0;
    rsp_data_d   = rsp_data_q;
    dbg_rvalid_d = 1'b0;
    dbg_rdata_d  = dbg_rdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (clr_start_i) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end else if (dbg_gnt) begin
          last_dbg_d = 1'b1;
          if (!bus.dbg_we) begin
            dbg_rvalid_d = 1'b1;
            dbg_rdata_d  = ram_rdata_i;
          end
        end else if (cmd_accept) begin
          last_dbg_d = 1'b0;
          unique case (op)
            OP_RIGHT: ptr_d = ptr_q + ADDR_ONE;
            OP_LEFT:  ptr_d = ptr_q - ADDR_ONE;
            OP_PEEK: begin
              rsp_valid_d = 1'b1;
              rsp_data_d  = ram_rdata_i;
            end
            default: ;
          endcase
        end
      end

      S_CLEAR: begin
        cnt_d = cnt_q + ADDR_ONE;
        if (cnt_q == CNT_LAST) begin
          ptr_d   = '0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Address side kept apart from the data side: ram_wdata depends on
  // ram_rdata, which the RAM derives combinationally from ram_addr.
  always_comb begin
    ram_addr_o    = ptr_q;
    bus.cmd_ready = cmd_ready;
    bus.dbg_gnt   = dbg_gnt;
    clr_busy_o    = (state_q == S_CLEAR);
    if (!nrst) begin
      ram_addr_o = '0;
    end else if (state_q == S_CLEAR) begin
      ram_addr_o = cnt_q;
    end else if (dbg_gnt) begin
      ram_addr_o = bus.dbg_addr;
    end
  end

  // The RAM writes on every edge, so any cycle without a real write must
  // write the current cell back unchanged.
  always_comb begin
    ram_wdata_o = ram_rdata_i;
    if (!nrst || state_q == S_CLEAR) begin
      ram_wdata_o = '0;
    end else if (dbg_gnt) begin
      if (bus.dbg_we) begin
        ram_wdata_o = bus.dbg_wdata;
      end
    end else if (cmd_accept) begin
      unique case (op)
        OP_INC:  ram_wdata_o = ram_rdata_i + DATA_ONE;
        OP_DEC:  ram_wdata_o = ram_rdata_i - DATA_ONE;
        OP_LOAD: ram_wdata_o = bus.cmd_wdata;
        default: ;
      endcase
    end
  end

  assign bus.zero_flag  = (ram_rdata_i == '0);
  assign bus.ptr        = ptr_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.dbg_rvalid = dbg_rvalid_q;
  assign bus.dbg_rdata  = dbg_rdata_q;

endmodule

// File: tb/tb_bf_tape_ctrl.sv
// Directed bench for bf_tape_ctrl with a behavioural tape RAM
// (async read, write every edge, clears itself while nrst is low).
module tb_bf_tape_ctrl;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 6;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_INC   = 3'd1;
  localparam logic [2:0] OP_DEC   = 3'd2;
  localparam logic [2:0] OP_RIGHT = 3'd3;
  localparam logic [2:0] OP_LEFT  = 3'd4;
  localparam logic [2:0] OP_LOAD  = 3'd5;
  localparam logic [2:0] OP_PEEK  = 3'd6;

  logic              clk = 1'b0;
  logic              nrst = 1'b0;
  logic              clr_start;
  logic              clr_busy;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] mem [64];

  int checks = 0;
  int errors = 0;
  int bad;

  always #5 clk = ~clk;

  bf_tape_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  bf_tape_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .nrst        (nrst),
    .bus         (bus),
    .clr_start_i (clr_start),
    .clr_busy_o  (clr_busy),
    .ram_addr_o  (ram_addr),
    .ram_wdata_o (ram_wdata),
    .ram_rdata_i (ram_rdata)
  );

  assign ram_rdata = mem[ram_addr];

  always @(posedge clk) begin
    if (!nrst) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
    end else begin
      mem[ram_addr] <= ram_wdata;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [7:0] wd, input string tag);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_wdata = wd;
    #1;
    checkOutput({tag, "_ready"}, 32'(bus.cmd_ready), 32'd1);
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic countNonzero(output int n);
    n = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== 8'h00) n++;
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_NOP;
    bus.cmd_wdata = '0;
    bus.dbg_req   = 1'b0;
    bus.dbg_we    = 1'b0;
    bus.dbg_addr  = '0;
    bus.dbg_wdata = '0;
    clr_start     = 1'b0;

    // Reset state
    tick();
    tick();
    checkOutput("rst_ptr", 32'(bus.ptr), 32'd0);
    checkOutput("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
    checkOutput("rst_dbg_rvalid", 32'(bus.dbg_rvalid), 32'd0);
    checkOutput("rst_dbg_rdata", 32'(bus.dbg_rdata), 32'd0);
    checkOutput("rst_clr_busy", 32'(clr_busy), 32'd0);
    nrst = 1'b1;
    #1;
    checkOutput("idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    checkOutput("idle_zero_flag", 32'(bus.zero_flag), 32'd1);

    // Basic op sequence
    applyStimulus(OP_INC, 8'h00, "inc1");
    applyStimulus(OP_INC, 8'h00, "inc2");
    applyStimulus(OP_INC, 8'h00, "inc3");
    applyStimulus(OP_RIGHT, 8'h00, "right1");
    applyStimulus(OP_DEC, 8'h00, "dec1");
    checkOutput("seq_cell0", 32'(mem[0]), 32'd3);
    checkOutput("seq_cell1", 32'(mem[1]), 32'd255);
    checkOutput("seq_ptr", 32'(bus.ptr), 32'd1);
    checkOutput("seq_zero_flag", 32'(bus.zero_flag), 32'd0);

    // Pointer and data wrap
    applyStimulus(OP_LEFT, 8'h00, "left1");
    checkOutput("left_ptr0", 32'(bus.ptr), 32'd0);
    applyStimulus(OP_LEFT, 8'h00, "left_wrap");
    checkOutput("wrap_ptr63", 32'(bus.ptr), 32'd63);
    applyStimulus(OP_RIGHT, 8'h00, "right_wrap");
    checkOutput("wrap_ptr0", 32'(bus.ptr), 32'd0);
    applyStimulus(OP_RIGHT, 8'h00, "right2");
    applyStimulus(OP_INC, 8'h00, "inc_wrap");
    checkOutput("wrap_cell1", 32'(mem[1]), 32'd0);
    checkOutput("wrap_zero_flag", 32'(bus.zero_flag), 32'd1);

    // LOAD then PEEK
    applyStimulus(OP_LOAD, 8'h41, "load");
    applyStimulus(OP_PEEK, 8'h00, "peek");
    checkOutput("peek_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    checkOutput("peek_rsp_data", 32'(bus.rsp_data), 32'h41);
    tick();
    checkOutput("peek_rsp_pulse", 32'(bus.rsp_valid), 32'd0);
    checkOutput("peek_cell1", 32'(mem[1]), 32'h41);
    checkOutput("hold_ram_addr", 32'(ram_addr), 32'd1);
    checkOutput("hold_ram_wdata", 32'(ram_wdata), 32'h41);

    // Contention from reset: dbg, cmd, dbg, cmd
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    bus.dbg_req   = 1'b1;
    bus.dbg_we    = 1'b0;
    bus.dbg_addr  = 6'd0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_INC;
    #1;
    checkOutput("arb1_dbg_gnt", 32'(bus.dbg_gnt), 32'd1);
    checkOutput("arb1_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    tick();
    checkOutput("arb2_dbg_rvalid", 32'(bus.dbg_rvalid), 32'd1);
    checkOutput("arb2_dbg_rdata", 32'(bus.dbg_rdata), 32'd0);
    checkOutput("arb2_dbg_gnt", 32'(bus.dbg_gnt), 32'd0);
    checkOutput("arb2_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    tick();
    checkOutput("arb3_dbg_gnt", 32'(bus.dbg_gnt), 32'd1);
    checkOutput("arb3_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    tick();
    checkOutput("arb4_dbg_rdata", 32'(bus.dbg_rdata), 32'd1);
    checkOutput("arb4_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    tick();
    bus.dbg_req   = 1'b0;
    bus.cmd_valid = 1'b0;
    checkOutput("arb_cell0", 32'(mem[0]), 32'd2);

    // Host write
    bus.dbg_req   = 1'b1;
    bus.dbg_we    = 1'b1;
    bus.dbg_addr  = 6'd5;
    bus.dbg_wdata = 8'h77;
    #1;
    checkOutput("dbgw_gnt", 32'(bus.dbg_gnt), 32'd1);
    tick();
    bus.dbg_req = 1'b0;
    checkOutput("dbgw_cell5", 32'(mem[5]), 32'h77);
    checkOutput("dbgw_no_rvalid", 32'(bus.dbg_rvalid), 32'd0);

    // Soft clear: start beats both requesters, then 64 busy cycles
    applyStimulus(OP_RIGHT, 8'h00, "pre_clr_right");
    clr_start     = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_INC;
    bus.dbg_req   = 1'b1;
    bus.dbg_addr  = 6'd7;
    bus.dbg_wdata = 8'h99;
    #1;
    checkOutput("clr_start_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    checkOutput("clr_start_dbg_gnt", 32'(bus.dbg_gnt), 32'd0);
    tick();
    clr_start     = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.dbg_req   = 1'b0;
    #1;
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      if (!(clr_busy === 1'b1 && bus.cmd_ready === 1'b0 && bus.dbg_gnt === 1'b0)) bad++;
      tick();
    end
    checkOutput("clr_busy_cycles", 32'(bad), 32'd0);
    checkOutput("clr_done_busy", 32'(clr_busy), 32'd0);
    checkOutput("clr_done_ready", 32'(bus.cmd_ready), 32'd1);
    checkOutput("clr_done_ptr", 32'(bus.ptr), 32'd0);
    checkOutput("clr_done_zero_flag", 32'(bus.zero_flag), 32'd1);
    checkOutput("clr_cell7", 32'(mem[7]), 32'd0);
    countNonzero(bad);
    checkOutput("clr_nonzero_cells", 32'(bad), 32'd0);

    // Reset in the middle of a sweep
    applyStimulus(OP_INC, 8'h00, "pre_rst_inc");
    applyStimulus(OP_RIGHT, 8'h00, "pre_rst_right");
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    repeat (10) tick();
    checkOutput("midclr_busy", 32'(clr_busy), 32'd1);
    nrst = 1'b0;
    tick();
    checkOutput("midrst_busy", 32'(clr_busy), 32'd0);
    checkOutput("midrst_ptr", 32'(bus.ptr), 32'd0);
    countNonzero(bad);
    checkOutput("midrst_nonzero_cells", 32'(bad), 32'd0);
    nrst = 1'b1;
    #1;
    checkOutput("midrst_cmd_ready", 32'(bus.cmd_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
